jtframe_pll_rstgen: RTL and testbench

Reset sequencer and clock-enable generator directly downstream of the 48 MHz system PLL. Synchronises the PLL `locked` flag, holds the SDRAM controller and the game core in reset until lock has been stable, then releases the SDRAM controller first and the game core afterwards. Once the core is running, it produces fractional-rate `cen`/`cenb` strobes for the core.

---
 rtl/jtframe_pll_rstgen.sv | 136 +++++++++++++
 tb/tb_jtframe_pll_rstgen.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_pll_rstgen.sv
// Reset sequencer and fractional clock-enable generator behind the system PLL.
// Optional: define JTFRAME_LOCK_WATCHDOG_EN to re-run the reset sequence on lock loss in RUN.
//
// state     | meaning
// WAIT_LOCK | counter cleared, waiting for synchronised lock
// STABLE    | lock must hold for LOCK_CYCLES consecutive cycles
// SDRAM     | SDRAM out of reset, core held for SDRAM_CYCLES
// RUN       | core running, cen/cenb active
module jtframe_pll_rstgen #(
  parameter int LOCK_CYCLES  = 1024,
  parameter int SDRAM_CYCLES = 4800,
  parameter int CEN_NUM      = 1,
  parameter int CEN_DEN      = 8,
  parameter int CW           = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       rst_sdram,
  output logic       rst_game,
  output logic       rst_n_game,
  output logic       cen,
  output logic       cenb,
  output logic [1:0] st
);

  localparam int CNT_MAX = (LOCK_CYCLES > SDRAM_CYCLES) ? LOCK_CYCLES : SDRAM_CYCLES;
  localparam int CNTW    = $clog2(CNT_MAX + 1);
  localparam logic [CNTW-1:0] LOCK_TC  = CNTW'(LOCK_CYCLES - 1);
  localparam logic [CNTW-1:0] SDRAM_TC = CNTW'(SDRAM_CYCLES - 1);
  localparam logic [CW-1:0]   NUM      = CW'(CEN_NUM);
  localparam logic [CW-1:0]   DEN      = CW'(CEN_DEN);
  localparam logic [CW-1:0]   HALF     = CW'(CEN_DEN / 2);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    SDRAM     = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [CNTW-1:0] cnt, cnt_nxt;
  logic            lock_m, lock_s;
  logic [CW-1:0]   acc, acc_sum;
  logic            game_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= pll_locked;
      lock_s <= lock_m;
    end
  end

  // Lock loss is checked before the terminal count so a drop always wins.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      WAIT_LOCK: begin
        cnt_nxt = '0;
        if (lock_s) state_nxt = STABLE;
      end
      STABLE: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == LOCK_TC) begin
          state_nxt = SDRAM;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNTW'(1);
        end
      end
      SDRAM: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == SDRAM_TC) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNTW'(1);
        end
      end
      RUN: begin
        cnt_nxt = '0;
`ifdef JTFRAME_LOCK_WATCHDOG_EN
        if (!lock_s) state_nxt = WAIT_LOCK;
`endif
      end
      default: begin
        state_nxt = WAIT_LOCK;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign acc_sum  = acc + NUM;
  assign game_nxt = (state_nxt != RUN);

  // The accumulator also clears on the edge that re-asserts rst_game, so no stray strobe escapes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= WAIT_LOCK;
      cnt        <= '0;
      rst_sdram  <= 1'b1;
      rst_game   <= 1'b1;
      rst_n_game <= 1'b0;
      acc        <= '0;
      cen        <= 1'b0;
      cenb       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      rst_sdram  <= (state_nxt == WAIT_LOCK) || (state_nxt == STABLE);
      rst_game   <= game_nxt;
      rst_n_game <= !game_nxt;
      if (rst_game || game_nxt) begin
        acc  <= '0;
        cen  <= 1'b0;
        cenb <= 1'b0;
      end else begin
        cen  <= (acc_sum >= DEN);
        acc  <= (acc_sum >= DEN) ? acc_sum - DEN : acc_sum;
        cenb <= (acc < HALF) && (acc_sum >= HALF);
      end
    end
  end

  assign st = state;

endmodule

// File: tb/tb_jtframe_pll_rstgen.sv
// Bench for jtframe_pll_rstgen: lock run-length reference model plus directed timing checks.
module tb_jtframe_pll_rstgen;

  localparam int LOCK = 16;
  localparam int SDR  = 32;
  localparam int DEN  = 8;
`ifdef JTFRAME_LOCK_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pll_locked = 1'b0;
  logic rst_sdram, rst_game, rst_n_game, cen, cenb;
  logic [1:0] st;
  logic rst_sdram3, rst_game3, rst_n_game3, cen3, cenb3;
  logic [1:0] st3;

  jtframe_pll_rstgen #(.LOCK_CYCLES(LOCK), .SDRAM_CYCLES(SDR), .CEN_NUM(1), .CEN_DEN(DEN), .CW(10)) u_dut (
    .clk(clk), .rst(rst), .pll_locked(pll_locked),
    .rst_sdram(rst_sdram), .rst_game(rst_game), .rst_n_game(rst_n_game),
    .cen(cen), .cenb(cenb), .st(st)
  );

  jtframe_pll_rstgen #(.LOCK_CYCLES(LOCK), .SDRAM_CYCLES(SDR), .CEN_NUM(3), .CEN_DEN(DEN), .CW(10)) u_dut3 (
    .clk(clk), .rst(rst), .pll_locked(pll_locked),
    .rst_sdram(rst_sdram3), .rst_game(rst_game3), .rst_n_game(rst_n_game3),
    .cen(cen3), .cenb(cenb3), .st(st3)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // reference model: lock history as a run length, RUN phase as elapsed cycles
  bit m_a1, m_ls, m_run;
  int m_r, m_t;

  int edge_n;
  int f_sdram, f_game, f_cenb, f_cen;
  int w_lo, w_hi, n_cen, n_cen3, n_cenb3, n_both3;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // strobes = multiples of DEN (cen) or DEN/2 + k*DEN (cenb) crossed by t*num
  function automatic int cen_exp(input int t, input int num);
    if (t < 1) return 0;
    return (t * num) / DEN - ((t - 1) * num) / DEN;
  endfunction

  function automatic int cenb_exp(input int t, input int num);
    if (t < 1) return 0;
    return (t * num + DEN / 2) / DEN - ((t - 1) * num + DEN / 2) / DEN;
  endfunction

  task automatic model_edge(input bit r, input bit l);
    bit ls_old;
    if (r) begin
      m_a1 = 0; m_ls = 0; m_r = 0; m_run = 0; m_t = 0;
    end else begin
      ls_old = m_ls;
      m_ls   = m_a1;
      m_a1   = l;
      if (m_run && (ls_old || !WD)) m_t++;
      else if (m_run) begin
        m_run = 0; m_r = 0;
      end else if (ls_old) begin
        m_r++;
        if (m_r > LOCK + SDR) begin
          m_run = 1; m_t = 0;
        end
      end else m_r = 0;
    end
  endtask

  task automatic check_all();
    int exp_st;
    exp_st = m_run ? 3 : (m_r == 0) ? 0 : (m_r <= LOCK) ? 1 : 2;
    chk("st", st, exp_st);
    chk("rst_sdram", rst_sdram, exp_st < 2);
    chk("rst_game", rst_game, exp_st != 3);
    chk("rst_n_game", rst_n_game, exp_st == 3);
    chk("cen", cen, m_run ? cen_exp(m_t, 1) : 0);
    chk("cenb", cenb, m_run ? cenb_exp(m_t, 1) : 0);
    chk("rst_game_3_8", rst_game3, exp_st != 3);
    chk("cen_3_8", cen3, m_run ? cen_exp(m_t, 3) : 0);
    chk("cenb_3_8", cenb3, m_run ? cenb_exp(m_t, 3) : 0);
  endtask

  task automatic start_scn(input int lo, input int hi);
    edge_n = 0;
    f_sdram = -1; f_game = -1; f_cenb = -1; f_cen = -1;
    w_lo = lo; w_hi = hi;
    n_cen = 0; n_cen3 = 0; n_cenb3 = 0; n_both3 = 0;
  endtask

  task automatic cyc(input bit r, input bit l);
    rst = r;
    pll_locked = l;
    @(posedge clk);
    model_edge(r, l);
    #1;
    check_all();
    if (f_sdram < 0 && rst_sdram === 1'b0) f_sdram = edge_n;
    if (f_game  < 0 && rst_game  === 1'b0) f_game  = edge_n;
    if (f_cenb  < 0 && cenb      === 1'b1) f_cenb  = edge_n;
    if (f_cen   < 0 && cen       === 1'b1) f_cen   = edge_n;
    if (edge_n >= w_lo && edge_n <= w_hi) begin
      n_cen   += int'(cen);
      n_cen3  += int'(cen3);
      n_cenb3 += int'(cenb3);
      n_both3 += int'(cen3 & cenb3);
    end
    edge_n++;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    start_scn(0, -1);
    @(negedge clk);

    // release sequence
    repeat (4) cyc(1'b1, 1'b0);
    chk("reset_st", st, 0);
    chk("reset_rst_n_game", rst_n_game, 0);
    start_scn(51, 114);
    repeat (120) cyc(1'b0, 1'b1);
    chk("rel_sdram_fall", f_sdram, 18);
    chk("rel_game_fall", f_game, 50);
    chk("rel_first_cenb", f_cenb, 54);
    chk("rel_first_cen", f_cen, 58);
    chk("rel_cen_1_8_count", n_cen, 8);
    chk("cen_3_8_count", n_cen3, 24);
    chk("cenb_3_8_count", n_cenb3, 24);
    chk("cen_cenb_coincident", n_both3, 0);

    // lock loss in RUN
    start_scn(2, 33);
    repeat (3) cyc(1'b0, 1'b0);
    chk("loss_rst_game", rst_game, WD);
    chk("loss_rst_sdram", rst_sdram, WD);
    repeat (31) cyc(1'b0, 1'b0);
    chk("loss_cen_count", n_cen, WD ? 0 : 4);
    start_scn(0, -1);
    repeat (60) cyc(1'b0, 1'b1);
    chk("relock_sdram_fall", f_sdram, WD ? 18 : 0);
    chk("relock_game_fall", f_game, WD ? 50 : 0);

    // one-cycle lock glitch at STABLE counter = 10
    repeat (2) cyc(1'b1, 1'b0);
    start_scn(0, -1);
    repeat (13) cyc(1'b0, 1'b1);
    chk("glitch_pre_st", st, 1);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    chk("glitch_e14_st", st, 1);
    cyc(1'b0, 1'b1);
    chk("glitch_e15_st", st, 0);
    cyc(1'b0, 1'b1);
    chk("glitch_reentry_st", st, 1);
    repeat (30) cyc(1'b0, 1'b1);
    chk("glitch_sdram_fall", f_sdram, 32);

    // reset pulse at SDRAM counter = 20
    repeat (2) cyc(1'b1, 1'b0);
    start_scn(0, -1);
    repeat (39) cyc(1'b0, 1'b1);
    chk("sdram_pre_st", st, 2);
    cyc(1'b1, 1'b1);
    chk("rst_in_sdram_st", st, 0);
    chk("rst_in_sdram_rst_sdram", rst_sdram, 1);
    chk("rst_in_sdram_rst_game", rst_game, 1);
    chk("rst_in_sdram_cen", {cen, cenb}, 0);
    start_scn(0, -1);
    repeat (30) cyc(1'b0, 1'b1);
    chk("rst_in_sdram_refall", f_sdram, 18);

    // randomized lock/reset traffic against the model
    for (int k = 0; k < 80; k++) begin
      int len;
      bit lv, rv;
      lv  = ($urandom_range(0, 3) != 0);
      len = lv ? $urandom_range(1, 120) : $urandom_range(1, 6);
      rv  = ($urandom_range(0, 19) == 0);
      for (int j = 0; j < len; j++) cyc(rv && (j < 2), lv);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
